mem_arbiter: RTL

- Two-port arbiter that shares the single unified memory port between requester 0 (CPU core: fetch/load/store) and requester 1 (program loader / debug access).
- Sits between the core's memory interface and the memory array.
- One transaction in flight at a time, round-robin between requesters.
- Because the core's accesses are no longer single-cycle, the core holds its state until it receives m0_gnt (reads: until m0_rvalid).

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_rr_arb2.sv | 36 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Requester index, FSM state encoding and latency counter sizing.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef logic req_idx_t;

  localparam req_idx_t RR_RESET = 1'b1;
  localparam int       LAT_MAX  = 4;
  localparam int       CNT_W    = $clog2(LAT_MAX);

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Combinational two-way round-robin picker.
// On a tie the requester that was not served last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   rr_last,
  output logic       valid,
  output req_idx_t   winner
);

  // Pick the winner from the request pair and the last-served index
  always_comb begin
    valid  = 1'b0;
    winner = 1'b0;
    case (req)
      2'b01: begin
        valid  = 1'b1;
        winner = 1'b0;
      end
      2'b10: begin
        valid  = 1'b1;
        winner = 1'b1;
      end
      2'b11: begin
        valid  = 1'b1;
        winner = ~rr_last;
      end
      default: begin
        valid  = 1'b0;
        winner = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the core (m0) and the loader/debug port (m1).
// One transaction in flight; all requester and memory outputs are registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WD_W   = 16,
  parameter int RD_W   = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [WD_W-1:0]   m0_wd,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [RD_W-1:0]   m0_rd,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [WD_W-1:0]   m1_wd,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [RD_W-1:0]   m1_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WD_W-1:0]   mem_wd,
  input  logic [RD_W-1:0]   mem_rd,
  output logic              busy
);

  state_t            state_r, state_s;
  req_idx_t          rr_last_r, owner_r, winner_s;
  logic              win_valid_s, take_s, resp_s;
  logic              win_we_s, we_r;
  logic [ADDR_W-1:0] win_addr_s, addr_r;
  logic [WD_W-1:0]   win_wd_s, wd_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              m0_gnt_r, m1_gnt_r, m0_rvalid_r, m1_rvalid_r;
  logic              mem_we_r, busy_r;
  logic [RD_W-1:0]   m0_rd_r, m1_rd_r;

  rr_arb2 u_pick (
    .req     ({m1_req, m0_req}),
    .rr_last (rr_last_r),
    .valid   (win_valid_s),
    .winner  (winner_s)
  );

  // Steer the winning requester's access fields
  always_comb begin
    win_we_s   = 1'b0;
    win_addr_s = {ADDR_W{1'b0}};
    win_wd_s   = {WD_W{1'b0}};
    if (winner_s == 1'b1) begin
      win_we_s   = m1_we;
      win_addr_s = m1_addr;
      win_wd_s   = m1_wd;
    end else begin
      win_we_s   = m0_we;
      win_addr_s = m0_addr;
      win_wd_s   = m0_wd;
    end
  end

  // Next-state logic; a read spends LAT cycles in WAIT before RESP
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) state_s = ACCESS;
        else             state_s = IDLE;
      end
      ACCESS: begin
        if (we_r) state_s = IDLE;
        else      state_s = WAIT;
      end
      WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) state_s = RESP;
        else                        state_s = WAIT;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  assign take_s = (state_r == IDLE) && win_valid_s;
  assign resp_s = (state_r == WAIT) && (state_s == RESP);

  // State, latched request, latency counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      rr_last_r   <= RR_RESET;
      owner_r     <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wd_r        <= {WD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      m0_gnt_r    <= 1'b0;
      m1_gnt_r    <= 1'b0;
      m0_rvalid_r <= 1'b0;
      m1_rvalid_r <= 1'b0;
      m0_rd_r     <= {RD_W{1'b0}};
      m1_rd_r     <= {RD_W{1'b0}};
      mem_we_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      if (take_s) begin
        owner_r   <= winner_s;
        rr_last_r <= winner_s;
        we_r      <= win_we_s;
        addr_r    <= win_addr_s;
        wd_r      <= win_wd_s;
      end
      if (state_r == ACCESS) begin
        cnt_r <= CNT_W'(LAT - 1);
      end else if ((state_r == WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
      m0_gnt_r    <= take_s && (winner_s == 1'b0);
      m1_gnt_r    <= take_s && (winner_s == 1'b1);
      mem_we_r    <= take_s && win_we_s;
      // Read data is sampled in the last WAIT cycle and presented during RESP
      m0_rvalid_r <= resp_s && (owner_r == 1'b0);
      m1_rvalid_r <= resp_s && (owner_r == 1'b1);
      if (resp_s && (owner_r == 1'b0)) m0_rd_r <= mem_rd;
      if (resp_s && (owner_r == 1'b1)) m1_rd_r <= mem_rd;
      busy_r <= (state_s != IDLE);
    end
  end

  assign m0_gnt    = m0_gnt_r;
  assign m1_gnt    = m1_gnt_r;
  assign m0_rvalid = m0_rvalid_r;
  assign m1_rvalid = m1_rvalid_r;
  assign m0_rd     = m0_rd_r;
  assign m1_rd     = m1_rd_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  assign mem_wd    = wd_r;
  assign busy      = busy_r;

endmodule
